pipe_accum_alu: RTL and testbench

Parametrised, pipelined successor to the single 8-bit registered adder in the tinycan top level. Computes unsigned add, subtract, accumulate or de-accumulate on two WIDTH-bit operands. Supports optional saturation, carry/borrow and sticky-overflow flags, and a configurable output pipeline depth. Sits between the tile's input pins and its output drivers; the top level maps ui_in/uio_in onto a/b and result onto uo_out.

---
 rtl/pipe_accum_alu.sv | 110 +++++++++++
 tb/tb_pipe_accum_alu.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_accum_alu.sv
// Pipelined unsigned add/sub/accumulate unit with optional saturation and sticky overflow.
// Stage 0 computes and owns the accumulator; later stages only delay the result.
module pipe_accum_alu #(
    parameter int WIDTH    = 8,
    parameter int STAGES   = 2,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    input  logic             clear,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf_sticky,
    output logic [WIDTH-1:0] acc
);

    // Handshake: in_valid is taken on every edge with ena high; there is no ready,
    // and out_valid pulses once per accepted op, STAGES enabled edges later.

    logic [WIDTH-1:0] acc_q;
    logic             ovf_q;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] op_y;
    logic [WIDTH:0]   raw;
    logic             cy0;
    logic [WIDTH-1:0] fin;

    // mode[1] selects accumulator forms, mode[0] selects subtraction.
    always_comb begin
        base = clear ? '0 : acc_q;
        op_x = mode[1] ? base : a;
        op_y = mode[1] ? a : b;
        if (mode[0]) begin
            raw = {1'b0, op_x} - {1'b0, op_y};
        end else begin
            raw = {1'b0, op_x} + {1'b0, op_y};
        end
        cy0 = raw[WIDTH];
        fin = raw[WIDTH-1:0];
        if (cy0 && (SATURATE != 0)) begin
            fin = mode[0] ? '0 : '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (ena) begin
            if (in_valid && mode[1]) begin
                acc_q <= fin;
            end else if (clear) begin
                acc_q <= '0;
            end
            if (clear) begin
                ovf_q <= in_valid & cy0;
            end else if (in_valid) begin
                ovf_q <= ovf_q | cy0;
            end
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             v_in;
        logic [WIDTH-1:0] d_in;
        logic             c_in;
        logic             v_q;
        logic [WIDTH-1:0] d_q;
        logic             c_q;

        if (i == 0) begin : g_first
            assign v_in = in_valid;
            assign d_in = fin;
            assign c_in = cy0;
        end else begin : g_next
            assign v_in = g_stage[i-1].v_q;
            assign d_in = g_stage[i-1].d_q;
            assign c_in = g_stage[i-1].c_q;
        end

        // Data loads only with a valid bit, so the last stage holds its last result.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                d_q <= '0;
                c_q <= 1'b0;
            end else if (ena) begin
                v_q <= v_in;
                if (v_in) begin
                    d_q <= d_in;
                    c_q <= c_in;
                end
            end
        end
    end

    assign out_valid  = g_stage[STAGES-1].v_q;
    assign result     = g_stage[STAGES-1].d_q;
    assign carry      = g_stage[STAGES-1].c_q;
    assign ovf_sticky = ovf_q;
    assign acc        = acc_q;

endmodule

// File: tb/tb_pipe_accum_alu.sv
// Directed bench for pipe_accum_alu: saturating and wrapping instances share stimulus.
module tb_pipe_accum_alu;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] mode;
    logic       clear;

    logic       out_valid, carry, ovf_sticky;
    logic [7:0] result, acc;
    logic       w_out_valid, w_carry, w_ovf;
    logic [7:0] w_result, w_acc;

    int checks;
    int failures;

    pipe_accum_alu #(.WIDTH(8), .STAGES(2), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .a(a), .b(b),
        .mode(mode), .clear(clear), .out_valid(out_valid), .result(result),
        .carry(carry), .ovf_sticky(ovf_sticky), .acc(acc)
    );

    pipe_accum_alu #(.WIDTH(8), .STAGES(2), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .a(a), .b(b),
        .mode(mode), .clear(clear), .out_valid(w_out_valid), .result(w_result),
        .carry(w_carry), .ovf_sticky(w_ovf), .acc(w_acc)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] va, input logic [7:0] vb,
                         input logic [1:0] vm, input logic vc);
        in_valid = v;
        a        = va;
        b        = vb;
        mode     = vm;
        clear    = vc;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
    endtask

    task automatic test_reset();
        drive(1'b1, 8'h33, 8'h00, 2'b10, 1'b0);
        step();
        idle();
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (result !== 8'h00) begin failures++; $display("FAIL rst_result: got %h want 00", result); end
        checks++; if (acc !== 8'h00) begin failures++; $display("FAIL rst_acc: got %h want 00", acc); end
        checks++; if (carry !== 1'b0 || ovf_sticky !== 1'b0) begin failures++; $display("FAIL rst_flags: got %b%b want 00", carry, ovf_sticky); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_idle_valid: got %b want 0", out_valid); end
        end
    endtask

    task automatic test_add();
        drive(1'b1, 8'h30, 8'h25, 2'b00, 1'b0);
        step();
        idle();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_early_valid: got %b want 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1 || result !== 8'h55 || carry !== 1'b0) begin failures++; $display("FAIL add_basic: got v=%b r=%h c=%b want v=1 r=55 c=0", out_valid, result, carry); end
        step();
        checks++; if (out_valid !== 1'b0 || result !== 8'h55) begin failures++; $display("FAIL add_hold: got v=%b r=%h want v=0 r=55", out_valid, result); end
        drive(1'b1, 8'hF0, 8'h20, 2'b00, 1'b0);
        step();
        idle();
        checks++; if (ovf_sticky !== 1'b1 || w_ovf !== 1'b1) begin failures++; $display("FAIL add_sticky: got %b/%b want 1/1", ovf_sticky, w_ovf); end
        step();
        checks++; if (result !== 8'hFF || carry !== 1'b1) begin failures++; $display("FAIL add_sat: got r=%h c=%b want r=ff c=1", result, carry); end
        checks++; if (w_result !== 8'h10 || w_carry !== 1'b1) begin failures++; $display("FAIL add_wrap: got r=%h c=%b want r=10 c=1", w_result, w_carry); end
        checks++; if (acc !== 8'h00) begin failures++; $display("FAIL add_acc_untouched: got %h want 00", acc); end
    endtask

    task automatic test_sub_back_to_back();
        drive(1'b1, 8'h10, 8'h20, 2'b01, 1'b0);
        step();
        drive(1'b1, 8'h20, 8'h10, 2'b01, 1'b0);
        step();
        idle();
        checks++; if (out_valid !== 1'b1 || result !== 8'h00 || carry !== 1'b1) begin failures++; $display("FAIL sub_borrow_sat: got v=%b r=%h c=%b want v=1 r=00 c=1", out_valid, result, carry); end
        checks++; if (w_result !== 8'hF0 || w_carry !== 1'b1) begin failures++; $display("FAIL sub_borrow_wrap: got r=%h c=%b want r=f0 c=1", w_result, w_carry); end
        step();
        checks++; if (out_valid !== 1'b1 || result !== 8'h10 || carry !== 1'b0) begin failures++; $display("FAIL sub_plain: got v=%b r=%h c=%b want v=1 r=10 c=0", out_valid, result, carry); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sub_tail_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_acc_chain();
        logic [7:0] exp_acc [4];
        exp_acc[0] = 8'h40; exp_acc[1] = 8'h80; exp_acc[2] = 8'hC0; exp_acc[3] = 8'hFF;
        drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
        step();
        checks++; if (acc !== 8'h00 || ovf_sticky !== 1'b0) begin failures++; $display("FAIL acc_pre_clear: got acc=%h s=%b want 00/0", acc, ovf_sticky); end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 8'h40, 8'h00, 2'b10, 1'b0);
            step();
            checks++; if (acc !== exp_acc[k]) begin failures++; $display("FAIL acc_chain_acc%0d: got %h want %h", k, acc, exp_acc[k]); end
            if (k > 0) begin
                checks++; if (out_valid !== 1'b1 || result !== exp_acc[k-1]) begin failures++; $display("FAIL acc_chain_res%0d: got v=%b r=%h want v=1 r=%h", k - 1, out_valid, result, exp_acc[k-1]); end
            end
        end
        idle();
        step();
        checks++; if (out_valid !== 1'b1 || result !== 8'hFF || carry !== 1'b1 || ovf_sticky !== 1'b1) begin failures++; $display("FAIL acc_chain_last: got v=%b r=%h c=%b s=%b want 1 ff 1 1", out_valid, result, carry, ovf_sticky); end
        drive(1'b1, 8'h0F, 8'h00, 2'b11, 1'b0);
        step();
        idle();
        checks++; if (acc !== 8'hF0) begin failures++; $display("FAIL dacc_acc: got %h want f0", acc); end
        step();
        checks++; if (result !== 8'hF0 || carry !== 1'b0) begin failures++; $display("FAIL dacc_res: got r=%h c=%b want f0 0", result, carry); end
    endtask

    task automatic test_clear();
        drive(1'b1, 8'h40, 8'h00, 2'b10, 1'b0);
        step();
        checks++; if (acc !== 8'hFF || ovf_sticky !== 1'b1) begin failures++; $display("FAIL clr_setup: got acc=%h s=%b want ff 1", acc, ovf_sticky); end
        drive(1'b1, 8'h05, 8'h00, 2'b10, 1'b1);
        step();
        idle();
        checks++; if (acc !== 8'h05 || ovf_sticky !== 1'b0) begin failures++; $display("FAIL clr_with_acc: got acc=%h s=%b want 05 0", acc, ovf_sticky); end
        step();
        checks++; if (out_valid !== 1'b1 || result !== 8'h05 || carry !== 1'b0) begin failures++; $display("FAIL clr_result: got v=%b r=%h c=%b want 1 05 0", out_valid, result, carry); end
        drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
        step();
        idle();
        checks++; if (acc !== 8'h00) begin failures++; $display("FAIL clr_alone: got %h want 00", acc); end
    endtask

    task automatic test_ena_stall();
        int seen;
        drive(1'b1, 8'h01, 8'h02, 2'b00, 1'b0);
        step();
        ena = 1'b0;
        drive(1'b1, 8'hFF, 8'hFF, 2'b10, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_valid%0d: got %b want 0", k, out_valid); end
        end
        checks++; if (acc !== 8'h00) begin failures++; $display("FAIL stall_acc: got %h want 00", acc); end
        idle();
        ena = 1'b1;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (out_valid === 1'b1) begin
                seen++;
                checks++; if (result !== 8'h03 || carry !== 1'b0) begin failures++; $display("FAIL stall_result: got r=%h c=%b want 03 0", result, carry); end
            end
        end
        checks++; if (seen != 1) begin failures++; $display("FAIL stall_count: got %0d want 1", seen); end
    endtask

    task automatic test_reset_midpipe();
        int seen;
        drive(1'b1, 8'h07, 8'h00, 2'b10, 1'b0);
        step();
        step();
        idle();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || acc !== 8'h00) begin failures++; $display("FAIL midrst_now: got v=%b acc=%h want 0 00", out_valid, acc); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (out_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0 || acc !== 8'h00) begin failures++; $display("FAIL midrst_after: got valids=%0d acc=%h want 0 00", seen, acc); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        ena      = 1'b1;
        idle();
        #12 rst_n = 1'b1;
        step();
        test_reset();
        test_add();
        test_sub_back_to_back();
        test_acc_chain();
        test_clear();
        test_ena_stall();
        test_reset_midpipe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
